// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction / data) arbiter in front of a single
//               asynchronous-style SRAM interface. An IDLE/ACCESS FSM grants
//               one requester at a time. Simultaneous requests alternate
//               round-robin, and an access that stays stalled for too long
//               is aborted with an error.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   i_req/i_addr        : instruction read request and address
//   i_ack/i_err/i_rdata : one-cycle completion pulse, abort flag, read data
//   i_hold              : instruction requester stall (i_req & ~i_ack)
//   d_req/d_we/d_bw     : data request, write enable, word(1)/byte(0) select
//   d_addr/d_wdata      : data address and write data
//   d_ack/d_err/d_rdata : one-cycle completion pulse, abort flag, read data
//   d_hold              : data requester stall (d_req & ~d_ack)
//   mem_*               : SRAM address, data, active-low strobes, byte/word
//                         select, and mem_hold busy input
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    // instruction port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic              i_err,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_hold,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_bw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_hold,
    // memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ce_n,
    output logic              mem_we_n,
    output logic              mem_oe_n,
    output logic              mem_bw,
    input  logic              mem_hold
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_last_d;     // 1: data port was granted last
    logic                r_grant_d;    // 1: current access belongs to data port
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic                r_bw;
    logic [c_cnt_w-1:0]  r_cnt;

    logic                r_i_ack;
    logic                r_i_err;
    logic [DATA_W-1:0]   r_i_rdata;
    logic                r_d_ack;
    logic                r_d_err;
    logic [DATA_W-1:0]   r_d_rdata;

    logic                w_i_valid;
    logic                w_d_valid;
    logic                w_grant;
    logic                w_grant_d;
    logic                w_done;
    logic                w_abort;
    logic                w_access;

    // A port whose ack is high this cycle is still showing its old request,
    // so it must not be re-granted on the same edge.
    assign w_i_valid = i_req & ~r_i_ack;
    assign w_d_valid = d_req & ~r_d_ack;

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_i_valid || w_d_valid) begin
                    w_grant      = 1'b1;
                    // Data wins when it is alone, or when both request and
                    // instruction was served last.
                    w_grant_d    = w_d_valid & (~w_i_valid | ~r_last_d);
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!mem_hold) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_d  <= 1'b1;
            r_grant_d <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_bw      <= 1'b1;
            r_cnt     <= '0;
            r_i_ack   <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_i_err <= 1'b0;
            r_d_ack <= 1'b0;
            r_d_err <= 1'b0;

            if (w_grant) begin
                r_grant_d <= w_grant_d;
                r_last_d  <= w_grant_d;
                r_cnt     <= '0;
                if (w_grant_d) begin
                    r_addr  <= d_addr;
                    r_we    <= d_we;
                    r_bw    <= d_bw;
                    r_wdata <= d_wdata;
                end else begin
                    r_addr  <= i_addr;
                    r_we    <= 1'b0;
                    r_bw    <= 1'b1;
                    r_wdata <= '0;
                end
            end

            if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            if (w_done || w_abort) begin
                if (r_grant_d) begin
                    r_d_ack   <= 1'b1;
                    r_d_err   <= w_abort;
                    r_d_rdata <= (w_abort || r_we) ? '0 : mem_rdata;
                end else begin
                    r_i_ack   <= 1'b1;
                    r_i_err   <= w_abort;
                    r_i_rdata <= w_abort ? '0 : mem_rdata;
                end
            end
        end
    end

    // Memory port is a pure decode of the state register, so an asynchronous
    // reset releases the RAM strobes immediately.
    assign w_access  = (r_state == ST_ACCESS);
    assign mem_ce_n  = ~w_access;
    assign mem_we_n  = w_access ? ~r_we : 1'b1;
    assign mem_oe_n  = w_access ? r_we : 1'b1;
    assign mem_bw    = w_access ? r_bw : 1'b1;
    assign mem_addr  = w_access ? r_addr : '0;
    assign mem_wdata = w_access ? r_wdata : '0;

    assign i_ack   = r_i_ack;
    assign i_err   = r_i_err;
    assign i_rdata = r_i_rdata;
    assign i_hold  = i_req & ~r_i_ack;

    assign d_ack   = r_d_ack;
    assign d_err   = r_d_err;
    assign d_rdata = r_d_rdata;
    assign d_hold  = d_req & ~r_d_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed table of
//               request rounds, hand-written reset/alternation sequences and
//               randomized rounds checked against a transaction-level model
//               (round-robin memory, latency = stall cycles + 1 capped at
//               TIMEOUT, RAM contents as a function of address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;
    localparam int P_I     = 0;
    localparam int P_D     = 1;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_req   = 1'b0;
    logic [ADDR_W-1:0] i_addr  = '0;
    logic              i_ack;
    logic              i_err;
    logic [DATA_W-1:0] i_rdata;
    logic              i_hold;
    logic              d_req   = 1'b0;
    logic              d_we    = 1'b0;
    logic              d_bw    = 1'b1;
    logic [ADDR_W-1:0] d_addr  = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_ack;
    logic              d_err;
    logic [DATA_W-1:0] d_rdata;
    logic              d_hold;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ce_n;
    logic              mem_we_n;
    logic              mem_oe_n;
    logic              mem_bw;
    logic              mem_hold;

    int                hold_cycles = 0;
    int                ram_cnt     = 0;
    int                n_checks    = 0;
    int                n_pass      = 0;

    // transaction-level model state
    int                mdl_last = P_D;
    logic [DATA_W-1:0] mdl_rdata [2];

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .i_rdata   (i_rdata),
        .i_hold    (i_hold),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_bw      (d_bw),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .d_hold    (d_hold),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ce_n  (mem_ce_n),
        .mem_we_n  (mem_we_n),
        .mem_oe_n  (mem_oe_n),
        .mem_bw    (mem_bw),
        .mem_hold  (mem_hold)
    );

    always #5 clk = ~clk;

    // RAM: content is a fixed function of the address; stalls for
    // hold_cycles cycles at the start of every access.
    function automatic logic [31:0] ramf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign mem_rdata = ramf(mem_addr);
    assign mem_hold  = (mem_ce_n === 1'b0) && (ram_cnt < hold_cycles);

    always @(posedge clk) begin
        ram_cnt <= (mem_ce_n === 1'b0) ? ram_cnt + 1 : 0;
    end

    function automatic int mdl_cycles(input int h);
        return (h < TIMEOUT) ? h + 1 : TIMEOUT;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Serve one access for port p, with the RAM stalling h cycles.
    task automatic serve(input int p, input int h, input int exp_cyc, input bit exp_err);
        int                n;
        bit                bad_stable;
        bit                bad_hold;
        logic [31:0]       e_addr;
        logic [31:0]       e_wdata;
        logic [31:0]       e_rdata;
        logic [2:0]        e_ctl;
        hold_cycles = h;
        if (p == P_I) begin
            e_addr  = i_addr;
            e_ctl   = 3'b101;
            e_wdata = '0;
            e_rdata = ramf(i_addr);
        end else begin
            e_addr  = d_addr;
            e_ctl   = {~d_we, d_we, d_bw};
            e_wdata = d_wdata;
            e_rdata = d_we ? 32'h0 : ramf(d_addr);
        end
        if (exp_err) e_rdata = '0;

        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (mem_ce_n !== 1'b0 && n < 4);
        check("start_latency", 64'(n), 64'(1));
        if (mem_ce_n !== 1'b0) begin
            if (p == P_I) i_req = 1'b0; else d_req = 1'b0;
            return;
        end
        check("mem_addr", 64'(mem_addr), 64'(e_addr));
        check("mem_we_oe_bw", 64'({mem_we_n, mem_oe_n, mem_bw}), 64'(e_ctl));
        check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));

        n          = 0;
        bad_stable = 1'b0;
        bad_hold   = 1'b0;
        while (i_ack !== 1'b1 && d_ack !== 1'b1 && n < TIMEOUT + 8) begin
            if (mem_ce_n !== 1'b0 || mem_addr !== e_addr || mem_wdata !== e_wdata ||
                {mem_we_n, mem_oe_n, mem_bw} !== e_ctl)
                bad_stable = 1'b1;
            if (((p == P_I) ? i_hold : d_hold) !== 1'b1) bad_hold = 1'b1;
            // idle requester wiggles its fields; must not disturb the access
            if (i_req == 1'b0) i_addr = $urandom;
            if (d_req == 1'b0) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_we    = 1'($urandom_range(0, 1));
                d_bw    = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            n++;
        end
        check("access_cycles", 64'(n), 64'(exp_cyc));
        check("ack_port", 64'({i_ack, d_ack}), (p == P_I) ? 64'(2'b10) : 64'(2'b01));
        check("err_flags", 64'({i_err, d_err}),
              (p == P_I) ? 64'({exp_err, 1'b0}) : 64'({1'b0, exp_err}));
        check("rdata", 64'((p == P_I) ? i_rdata : d_rdata), 64'(e_rdata));
        check("other_rdata_held", 64'((p == P_I) ? d_rdata : i_rdata), 64'(mdl_rdata[1-p]));
        check("hold_at_ack", 64'((p == P_I) ? i_hold : d_hold), 64'(0));
        check("idle_at_ack", 64'(mem_ce_n), 64'(1));
        check("mem_stable", 64'(bad_stable), 64'(0));
        check("req_hold", 64'(bad_hold), 64'(0));
        mdl_rdata[p] = e_rdata;
        mdl_last     = p;
        if (p == P_I) i_req = 1'b0; else d_req = 1'b0;
    endtask

    // A round: raise requests, serve all of them, then one idle cycle.
    // first >= 0 forces the expected first grant for simultaneous requests.
    task automatic round(input bit ri, input bit rd, input int first, input int h,
                         input int cyc, input bit err);
        bit pend [2];
        int p;
        pend[0] = ri;
        pend[1] = rd;
        i_req   = ri;
        d_req   = rd;
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) p = (first >= 0) ? first : 1 - mdl_last;
            else                    p = pend[0] ? P_I : P_D;
            serve(p, h, cyc, err);
            pend[p] = 1'b0;
        end
        @(posedge clk); #1;
        check("gap_idle", 64'(mem_ce_n), 64'(1));
    endtask

    typedef struct {
        bit          ri;
        bit          rd;
        logic [31:0] ia;
        bit          we;
        bit          bw;
        logic [31:0] da;
        logic [31:0] wd;
        int          h;
        int          first;
        int          cyc;
        bit          err;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish by 500us, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        int k;
        int h;

        tbl[0] = '{1'b1, 1'b1, 32'h0040_0000, 1'b0, 1'b1, 32'h2000_0010, 32'h0,        0,    P_I, 1,  1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h0040_0000, 1'b0, 1'b1, 32'h0,        32'h0,        0,    P_I, 1,  1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h1001_0000, 32'h0000_00A5, 16,  P_D, 17, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'h0040_0104, 1'b1, 1'b1, 32'h1001_0008, 32'hCAFE_F00D, 2,   P_I, 3,  1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h1001_0040, 32'h0,        63,   P_D, 64, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h0040_0200, 1'b0, 1'b0, 32'h1001_0003, 32'h0,        1,    P_I, 2,  1'b0};
        tbl[6] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h1001_0080, 32'h1234_5678, 1000, P_D, 64, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 32'h0040_0300, 1'b0, 1'b1, 32'h0,        32'h0,        100,  P_I, 64, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 32'h0040_0400, 1'b0, 1'b1, 32'h1001_0100, 32'h0,        0,    P_D, 1,  1'b0};

        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_strobes", 64'({mem_ce_n, mem_we_n, mem_oe_n, mem_bw}), 64'(4'b1111));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_acks_errs", 64'({i_ack, i_err, d_ack, d_err}), 64'(0));
        check("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
        check("rst_holds", 64'({i_hold, d_hold}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // both requests held continuously from the first cycle: I,D,I,D
        i_addr  = 32'h0040_0000;
        d_addr  = 32'h1000_0020;
        d_we    = 1'b0;
        d_bw    = 1'b1;
        i_req   = 1'b1;
        d_req   = 1'b1;
        serve(P_I, 0, 1, 1'b0);
        i_req = 1'b1;
        serve(P_D, 0, 1, 1'b0);
        d_req = 1'b1;
        serve(P_I, 0, 1, 1'b0);
        serve(P_D, 0, 1, 1'b0);
        @(posedge clk); #1;
        check("alt_gap_idle", 64'(mem_ce_n), 64'(1));

        // directed table
        for (int t = 0; t < 9; t++) begin
            i_addr  = tbl[t].ia;
            d_we    = tbl[t].we;
            d_bw    = tbl[t].bw;
            d_addr  = tbl[t].da;
            d_wdata = tbl[t].wd;
            round(tbl[t].ri, tbl[t].rd, tbl[t].first, tbl[t].h, tbl[t].cyc, tbl[t].err);
        end

        // randomized rounds against the model
        for (int r = 0; r < 60; r++) begin
            sel     = $urandom_range(0, 2);
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = 1'($urandom_range(0, 1));
            d_bw    = 1'($urandom_range(0, 1));
            k       = $urandom_range(0, 15);
            if (k == 0)      h = TIMEOUT + $urandom_range(0, 5);
            else if (k == 1) h = TIMEOUT - 1;
            else             h = $urandom_range(0, 4);
            round(sel != 1, sel != 0, -1, h, mdl_cycles(h), h >= TIMEOUT);
        end

        // reset in the middle of a stalled access
        d_addr      = 32'h1001_0200;
        d_we        = 1'b0;
        d_bw        = 1'b1;
        hold_cycles = 1000;
        d_req       = 1'b1;
        @(posedge clk); #1;
        check("rst_seq_access_started", 64'(mem_ce_n), 64'(0));
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_async_ce", 64'({mem_ce_n, mem_we_n, mem_oe_n}), 64'(3'b111));
        check("rst_async_acks", 64'({i_ack, d_ack, i_err, d_err}), 64'(0));
        check("rst_async_rdata", 64'({i_rdata, d_rdata}), 64'(0));
        d_req        = 1'b0;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        mdl_last     = P_D;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_ack", 64'({i_ack, d_ack, mem_ce_n}), 64'(3'b001));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_idle", 64'({i_ack, d_ack, mem_ce_n}), 64'(3'b001));
        i_addr  = 32'h0040_0800;
        d_addr  = 32'h1001_0300;
        d_we    = 1'b1;
        d_bw    = 1'b0;
        d_wdata = 32'h0000_005A;
        round(1'b1, 1'b1, P_I, 0, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
